// File: rtl/sequence_bram_writer.sv
// rtl/sequence_bram_writer.sv - streams sequence table words from AXI4-Stream into BRAM port A
//
// Ports:
//   aclk, areset            clock and asynchronous active-high reset
//   cfg_start / cfg_abort   single-cycle load start / abort pulses
//   cfg_base_addr           first BRAM word address of the load
//   cfg_length              number of words to load, 0..2^BRAM_ADDR_WIDTH
//   s_axis_*                sequence word stream (slave)
//   bram_porta_*            registered BRAM write port, clock/reset pass-through
//   sts_busy                load in progress
//   sts_done                sticky completion flag
//   sts_count               words written by the current or last load
//   sts_err_early_last      sticky: tlast seen before cfg_length words
//   sts_err_missing_last    sticky: final word arrived without tlast
module sequence_bram_writer #(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         cfg_start,
  input  logic                         cfg_abort,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_base_addr,
  input  logic [BRAM_ADDR_WIDTH:0]     cfg_length,
  input  logic [BRAM_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we,
  output logic                         sts_busy,
  output logic                         sts_done,
  output logic [BRAM_ADDR_WIDTH:0]     sts_count,
  output logic                         sts_err_early_last,
  output logic                         sts_err_missing_last
);

  localparam int WE_WIDTH = BRAM_DATA_WIDTH / 8;
  localparam logic [BRAM_ADDR_WIDTH:0] COUNT_ONE = {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [BRAM_ADDR_WIDTH:0] COUNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic [BRAM_ADDR_WIDTH-1:0]  base_q;
  logic [BRAM_ADDR_WIDTH:0]    length_q;
  logic [BRAM_ADDR_WIDTH:0]    count_q;
  logic                        accept;
  logic                        final_beat;
  logic                        start_ok;

  assign bram_porta_clk = aclk;
  assign bram_porta_rst = areset;

  // Abort drops tready in the same cycle so a coincident beat is never taken.
  assign s_axis_tready = (state_q == ST_WRITE) && !cfg_abort;
  assign accept        = s_axis_tvalid && s_axis_tready;
  // count never exceeds length-1 while writing, so count+1 cannot overflow.
  assign final_beat    = (count_q + COUNT_ONE) == length_q;
  assign start_ok      = (state_q == ST_IDLE) && cfg_start;
  assign sts_busy      = (state_q == ST_WRITE);
  assign sts_count     = count_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Start wins over a simultaneous abort; abort is meaningless here.
        if (cfg_start) begin
          state_d = (cfg_length == COUNT_ZERO) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (accept && (final_beat || s_axis_tlast)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      base_q               <= '0;
      length_q             <= '0;
      count_q              <= '0;
      bram_porta_addr      <= '0;
      bram_porta_wrdata    <= '0;
      bram_porta_we        <= '0;
      sts_done             <= 1'b0;
      sts_err_early_last   <= 1'b0;
      sts_err_missing_last <= 1'b0;
    end else begin
      bram_porta_we <= accept ? {WE_WIDTH{1'b1}} : {WE_WIDTH{1'b0}};

      if (accept) begin
        // Address arithmetic truncates to the table depth, giving the wrap.
        bram_porta_addr   <= base_q + count_q[BRAM_ADDR_WIDTH-1:0];
        bram_porta_wrdata <= s_axis_tdata;
        count_q           <= count_q + COUNT_ONE;
        if (final_beat && !s_axis_tlast) begin
          sts_err_missing_last <= 1'b1;
        end
        if (s_axis_tlast && !final_beat) begin
          sts_err_early_last <= 1'b1;
        end
      end

      if (start_ok) begin
        base_q               <= cfg_base_addr;
        length_q             <= cfg_length;
        count_q              <= '0;
        sts_done             <= 1'b0;
        sts_err_early_last   <= 1'b0;
        sts_err_missing_last <= 1'b0;
      end

      if (state_q == ST_DONE) begin
        sts_done <= 1'b1;
      end
    end
  end

endmodule
